// File: rtl/risc_pkg.sv
// Shared definitions for the multi-cycle RISC control path.
//   - fetch FSM state encoding (also exported as a debug output)
//   - opcode constants and IR field positions
//   - PC increment step
package risc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Opcode constants, ir[31:26]
  localparam logic [5:0] OP_ALU  = 6'b000000;
  localparam logic [5:0] OP_LD   = 6'b000001;
  localparam logic [5:0] OP_ST   = 6'b000010;
  localparam logic [5:0] OP_BR   = 6'b000011;
  localparam logic [5:0] OP_BMI  = 6'b000100;
  localparam logic [5:0] OP_BPL  = 6'b000101;
  localparam logic [5:0] OP_BZ   = 6'b000110;
  localparam logic [5:0] OP_MOVE = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b001001;
  localparam logic [5:0] OP_ANDI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001011;
  localparam logic [5:0] OP_CMOV = 6'b001100;
  localparam logic [5:0] OP_NOP  = 6'b111110;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // IR field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int FUNC_W  = 4;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/imem_if.sv
// Instruction-memory handshake bundle.
//   imem_req   master->slave  fetch request, held until imem_ack
//   imem_addr  master->slave  fetch address, stable while imem_req = 1
//   imem_ack   slave->master  imem_rdata valid this cycle
//   imem_rdata slave->master  fetched instruction word
// Handshake: a request is open from the first cycle imem_req is 1 up to and
// including the cycle imem_ack is 1; the word is taken in that ack cycle.
// An ack seen while imem_req is 0 carries no data and is ignored.
interface imem_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_pc_unit.sv
// PC / NPC registers with +4 adder, branch mux and sticky misalign flag.
//   clk, rst       clock, asynchronous active-low reset
//   load_npc       npc <= pc + 4 (wraps modulo 2^ADDR_W)
//   load_pc        pc  <= branch_taken ? aligned target : npc
//   branch_taken   select branch target on load_pc
//   branch_target  branch address; low two bits are dropped
//   pc, npc        register outputs
//   misalign       set when a taken branch had a non-word-aligned target
module pc_unit
  import risc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_npc,
  input  logic              load_pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic              misalign
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_npc;
  logic              r_misalign;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_pc_next = branch_taken ? {branch_target[ADDR_W-1:2], 2'b00} : r_npc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_npc      <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      if (load_npc) r_npc <= r_pc + ADDR_W'(PC_STEP);
      if (load_pc) begin
        r_pc <= w_pc_next;
        if (branch_taken && (branch_target[1:0] != 2'b00)) r_misalign <= 1'b1;
      end
    end
  end

  assign pc       = r_pc;
  assign npc      = r_npc;
  assign misalign = r_misalign;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetch FSM, fetch buffer, IR, and the PC unit.
//   clk, rst             clock, asynchronous active-low reset
//   ReadIM ... HALT      control strobes from the multi-cycle control FSM
//   branch_taken/_target branch decision and address from the datapath
//   imem                 instruction-memory handshake (master side)
//   fetch_busy           fetch outstanding; control FSM stalls while 1
//   pc, npc, ir          architectural registers
//   opcode, func         decoded IR fields
//   misalign, halted     status flags
//   dbg_state            current fetch FSM state
module instr_fetch_unit
  import risc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ReadIM,
  input  logic               LoadNPC,
  input  logic               LoadIR,
  input  logic               LoadPC,
  input  logic               HALT,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  imem_if.master             imem,
  output logic               fetch_busy,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  npc,
  output logic [INSTR_W-1:0] ir,
  output logic [5:0]         opcode,
  output logic [3:0]         func,
  output logic               misalign,
  output logic               halted,
  output fetch_state_e       dbg_state
);

  fetch_state_e       r_state, w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_buf;
  logic               r_buf_v;
  logic [INSTR_W-1:0] r_ir;
  logic               w_run;
  logic               w_start;
  logic               w_ack;

  // HALT wins over every other strobe, including in the cycle it arrives.
  assign w_run   = !HALT && (r_state != ST_HALTED);
  assign w_start = w_run && (r_state == ST_IDLE) && ReadIM;
  // Acks only count while a request is open; late acks after HALT or
  // reset find the FSM elsewhere and are dropped.
  assign w_ack   = w_run && (r_state == ST_REQ) && imem.imem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (HALT) begin
      w_next = ST_HALTED;
    end else begin
      case (r_state)
        ST_IDLE:   if (ReadIM) w_next = ST_REQ;
        ST_REQ:    if (imem.imem_ack) w_next = ST_IDLE;
        ST_HALTED: w_next = ST_HALTED;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= RESET_PC;
      r_buf   <= '0;
      r_buf_v <= 1'b0;
      r_ir    <= '0;
    end else begin
      if (w_start) begin
        r_addr  <= pc;
        r_buf_v <= 1'b0;
      end
      if (w_ack) begin
        r_buf   <= imem.imem_rdata;
        r_buf_v <= 1'b1;
      end
      if (w_run && LoadIR) begin
        if (w_ack)        r_ir <= imem.imem_rdata;
        else if (r_buf_v) r_ir <= r_buf;
      end
    end
  end

  pc_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc_unit (
    .clk           (clk),
    .rst           (rst),
    .load_npc      (LoadNPC && w_run),
    .load_pc       (LoadPC && w_run),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .npc           (npc),
    .misalign      (misalign)
  );

  assign imem.imem_req  = (r_state == ST_REQ);
  assign imem.imem_addr = r_addr;
  assign fetch_busy     = (r_state == ST_REQ);
  assign ir             = r_ir;
  assign opcode         = r_ir[OPC_MSB:OPC_LSB];
  assign func           = r_ir[FUNC_W-1:0];
  assign halted         = (r_state == ST_HALTED);
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import risc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        ReadIM = 0, LoadNPC = 0, LoadIR = 0, LoadPC = 0, HALT = 0;
  logic        branch_taken = 0;
  logic [31:0] branch_target = '0;
  logic        fetch_busy, misalign, halted;
  logic [31:0] pc, npc, ir;
  logic [5:0]  opcode;
  logic [3:0]  func;
  fetch_state_e dbg_state;

  imem_if #(.ADDR_W(32), .INSTR_W(32)) imem_bus ();

  instr_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .ReadIM        (ReadIM),
    .LoadNPC       (LoadNPC),
    .LoadIR        (LoadIR),
    .LoadPC        (LoadPC),
    .HALT          (HALT),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem_bus),
    .fetch_busy    (fetch_busy),
    .pc            (pc),
    .npc           (npc),
    .ir            (ir),
    .opcode        (opcode),
    .func          (func),
    .misalign      (misalign),
    .halted        (halted),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ir(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, ir, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ctrl();
    ReadIM = 0; LoadNPC = 0; LoadIR = 0; LoadPC = 0; HALT = 0;
    branch_taken = 0; branch_target = '0;
    imem_bus.imem_ack = 0; imem_bus.imem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_ctrl();
    rst = 0;
    tick();
    tick();
    rst = 1;
    tick();
  endtask

  task automatic branch_to(input logic [31:0] tgt);
    LoadPC = 1; branch_taken = 1; branch_target = tgt;
    tick();
    clear_ctrl();
  endtask

  logic [31:0] word2;

  initial begin
    clear_ctrl();
    @(negedge clk);
    do_reset();

    // 1: reset state, zero-wait fetch with bypass IR load
    check("rst_pc", pc, 32'h0);
    check("rst_npc", npc, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_req", {31'b0, imem_bus.imem_req}, 32'h0);
    check("rst_busy", {31'b0, fetch_busy}, 32'h0);
    check("rst_flags", {30'b0, misalign, halted}, 32'h0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});

    ReadIM = 1;
    tick();
    clear_ctrl();
    check("t1_req", {31'b0, imem_bus.imem_req}, 32'h1);
    check("t1_addr", imem_bus.imem_addr, 32'h0);
    imem_bus.imem_ack = 1; imem_bus.imem_rdata = 32'h2000_0000; LoadIR = 1;
    exp_q.push_back(32'h2000_0000);
    tick();
    clear_ctrl();
    check_ir("t1_ir");
    check("t1_opcode", {26'b0, opcode}, {26'b0, 6'b001000});
    check("t1_func", {28'b0, func}, 32'h0);
    check("t1_req_drop", {31'b0, imem_bus.imem_req}, 32'h0);

    // 2: ack three cycles late; LoadPC during REQ must not move imem_addr
    word2 = $urandom_range(32'h7FFF_FFFF, 32'h1000_0000);
    ReadIM = 1;
    tick();
    clear_ctrl();
    for (int i = 0; i < 3; i++) begin
      check("t2_busy", {31'b0, fetch_busy}, 32'h1);
      check("t2_addr", imem_bus.imem_addr, 32'h0);
      if (i == 0) begin LoadPC = 1; branch_taken = 1; branch_target = 32'h40; end
      if (i == 2) begin imem_bus.imem_ack = 1; imem_bus.imem_rdata = word2; end
      tick();
      clear_ctrl();
    end
    check("t2_busy_end", {31'b0, fetch_busy}, 32'h0);
    check("t2_pc", pc, 32'h40);
    check("t2_addr_held", imem_bus.imem_addr, 32'h0);
    LoadIR = 1;
    exp_q.push_back(word2);
    tick();
    clear_ctrl();
    check_ir("t2_ir_buf");

    // 3: NPC / PC sequencing and misaligned branch
    branch_to(32'h100);
    check("t3_pc100", pc, 32'h100);
    check("t3_mis0", {31'b0, misalign}, 32'h0);
    LoadNPC = 1;
    tick();
    clear_ctrl();
    check("t3_npc", npc, 32'h104);
    LoadPC = 1;
    tick();
    clear_ctrl();
    check("t3_pc_seq", pc, 32'h104);
    branch_to(32'h202);
    check("t3_pc_br", pc, 32'h200);
    check("t3_mis1", {31'b0, misalign}, 32'h1);

    // 4: NPC wrap, with ReadIM in the same cycle using the old pc
    branch_to(32'hFFFF_FFFC);
    ReadIM = 1; LoadNPC = 1;
    tick();
    clear_ctrl();
    check("t4_npc_wrap", npc, 32'h0);
    check("t4_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    check("t4_req", {31'b0, imem_bus.imem_req}, 32'h1);

    // 5: HALT during REQ, late ack ignored, later strobes ignored
    HALT = 1;
    tick();
    clear_ctrl();
    check("t5_req", {31'b0, imem_bus.imem_req}, 32'h0);
    check("t5_halted", {31'b0, halted}, 32'h1);
    imem_bus.imem_ack = 1; imem_bus.imem_rdata = 32'hDEAD_BEEF; LoadIR = 1;
    exp_q.push_back(word2);
    tick();
    clear_ctrl();
    check_ir("t5_ir_hold");
    ReadIM = 1; LoadPC = 1; branch_taken = 1; branch_target = 32'h80;
    tick();
    clear_ctrl();
    check("t5_pc_hold", pc, 32'hFFFF_FFFC);
    check("t5_req_off", {31'b0, imem_bus.imem_req}, 32'h0);
    check("t5_still_halted", {31'b0, halted}, 32'h1);

    // 6: asynchronous reset in the middle of a fetch
    do_reset();
    check("t6_unhalted", {31'b0, halted}, 32'h0);
    branch_to(32'h300);
    ReadIM = 1;
    tick();
    clear_ctrl();
    check("t6_req", {31'b0, imem_bus.imem_req}, 32'h1);
    #2 rst = 0;
    #1;
    check("t6_req_async", {31'b0, imem_bus.imem_req}, 32'h0);
    @(negedge clk);
    rst = 1;
    imem_bus.imem_ack = 1; imem_bus.imem_rdata = 32'hCAFE_F00D; LoadIR = 1;
    exp_q.push_back(32'h0);
    tick();
    clear_ctrl();
    check("t6_pc", pc, 32'h0);
    check_ir("t6_ir");
    check("t6_misalign", {31'b0, misalign}, 32'h0);
    check("t6_req_off", {31'b0, imem_bus.imem_req}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred ns long.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
